cpu_control_fsm: RTL

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm_pkg.sv | 44 ++++
 rtl/cpu_control_fsm_sat_counter16.sv | 17 +
 rtl/cpu_control_fsm.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_control_fsm_pkg.sv
// Shared CPU definitions: state encodings, opcode values and opcode classification.
package cpu_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_JMP,
        CLS_BEQZ,
        CLS_HALT
    } op_class_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1010;
    localparam logic [3:0] OP_BEQZ  = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // 0001-0111 are ALU operations; 1100-1110 are reserved and behave as NOP.
    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        cls = CLS_NOP;
        if (op == OP_HALT)        cls = CLS_HALT;
        else if (op == OP_LOAD)   cls = CLS_LOAD;
        else if (op == OP_STORE)  cls = CLS_STORE;
        else if (op == OP_JMP)    cls = CLS_JMP;
        else if (op == OP_BEQZ)   cls = CLS_BEQZ;
        else if (op[3] == 1'b0 && op != OP_NOP) cls = CLS_ALU;
        return cls;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_sat_counter16.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);

    // Count enabled cycles, saturating at 16'hFFFF.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en && count != '1)
            count <= count + 16'd1;
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with HALT.
// Strobes are registered from the next state, so each strobe is high exactly
// during the state it belongs to and none follows mem_ready combinationally.
module cpu_control_fsm
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        alu_en,
    output logic        rf_we,
    output logic        ldpc,
    output logic        jump,
    output logic        busy,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    state_t     state_q;
    state_t     nxt;
    logic [3:0] op_q;
    logic [3:0] op_nxt;
    logic       zero_q;
    logic       zero_nxt;
    op_class_t  cls_nxt;

    assign state = state_q;

    // Next-state selection plus the opcode/zero values that will be held next cycle.
    always_comb begin
        nxt      = ST_IDLE;
        op_nxt   = (state_q == ST_DECODE)  ? opcode : op_q;
        zero_nxt = (state_q == ST_EXECUTE) ? zero   : zero_q;
        case (state_q)
            ST_IDLE:      nxt = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:     nxt = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:    nxt = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   nxt = (op_class(op_q) == CLS_LOAD || op_class(op_q) == CLS_STORE)
                                ? ST_MEMORY : ST_WRITEBACK;
            ST_MEMORY:    nxt = mem_ready ? ST_WRITEBACK : ST_MEMORY;
            ST_WRITEBACK: nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:      nxt = ST_HALT;
            default:      nxt = ST_IDLE;
        endcase
        cls_nxt = op_class(op_nxt);
    end

    // State, latched opcode/zero and Moore strobes decoded for the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            zero_q  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ir_load <= 1'b0;
            alu_en  <= 1'b0;
            rf_we   <= 1'b0;
            ldpc    <= 1'b0;
            jump    <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state_q <= nxt;
            op_q    <= op_nxt;
            zero_q  <= zero_nxt;
            mem_req <= (nxt == ST_FETCH) || (nxt == ST_MEMORY);
            mem_we  <= (nxt == ST_MEMORY) && (cls_nxt == CLS_STORE);
            ir_load <= (nxt == ST_DECODE);
            alu_en  <= (nxt == ST_EXECUTE) &&
                       (cls_nxt == CLS_ALU || cls_nxt == CLS_LOAD || cls_nxt == CLS_STORE);
            rf_we   <= (nxt == ST_WRITEBACK) && (cls_nxt == CLS_ALU || cls_nxt == CLS_LOAD);
            ldpc    <= (nxt == ST_WRITEBACK);
            jump    <= (nxt == ST_WRITEBACK) &&
                       (cls_nxt == CLS_JMP || (cls_nxt == CLS_BEQZ && zero_nxt));
            busy    <= (nxt != ST_IDLE) && (nxt != ST_HALT);
            halted  <= (nxt == ST_HALT);
        end
    end

    sat_counter16 u_retired (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == ST_WRITEBACK),
        .count (retired)
    );

endmodule
